// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame scheduler: FSM encoding and constants.
package cam_pkg;

    localparam int   DROP_W    = 16;
    localparam logic MODE_WAIT = 1'b0;
    localparam logic MODE_DROP = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_STREAM = 3'd2,
        ST_STALL  = 3'd3,
        ST_RETRY  = 3'd4
    } state_t;

endpackage

// File: rtl/cam_ring_ptr.sv
// Frame-buffer ring bookkeeping: writer/reader indices and the count of full buffers.
// The full/drop flags are combinational so the FSM can react in the same cycle.
module cam_ring_ptr
    import cam_pkg::*;
#(
    parameter int NBUF = 2,
    parameter int BW   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_acc,
    input  logic          i_rd_acc,
    input  logic          i_stalled,
    input  logic          i_mode,
    output logic [BW-1:0] o_wr_buf,
    output logic [BW-1:0] o_rd_buf,
    output logic [BW:0]   o_fill,
    output logic [BW:0]   o_fill_nxt,
    output logic          o_full,
    output logic          o_drop
);

    localparam int            FW       = BW + 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(NBUF - 1);
    localparam logic [BW:0]   FILL_LIM = FW'(NBUF - 1);

    logic [BW-1:0] r_wr_buf, r_rd_buf;
    logic [BW:0]   r_fill;
    logic [BW:0]   w_fe, w_fill_nxt;
    logic          w_at_lim, w_full, w_drop, w_wr_adv;

    function automatic logic [BW-1:0] nxt_idx(input logic [BW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Next fill and pointer moves; a read in the same cycle frees a slot before the write is judged
    always_comb begin
        w_fe       = r_fill - {{BW{1'b0}}, i_rd_acc};
        w_at_lim   = i_wr_acc && (w_fe == FILL_LIM);
        w_full     = w_at_lim && (i_mode == MODE_WAIT);
        w_drop     = w_at_lim && (i_mode == MODE_DROP);
        w_fill_nxt = w_fe + {{BW{1'b0}}, (i_wr_acc && !w_drop)};
        // A stalled writer's buffer already counts as full; it advances once the reader frees one
        w_wr_adv   = (i_wr_acc && !w_at_lim) || (i_stalled && i_rd_acc);
    end

    // Pointer and fill registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_buf <= '0;
            r_rd_buf <= '0;
            r_fill   <= '0;
        end else begin
            r_fill <= w_fill_nxt;
            if (w_wr_adv) r_wr_buf <= nxt_idx(r_wr_buf);
            if (i_rd_acc) r_rd_buf <= nxt_idx(r_rd_buf);
        end
    end

    assign o_wr_buf   = r_wr_buf;
    assign o_rd_buf   = r_rd_buf;
    assign o_fill     = r_fill;
    assign o_fill_nxt = w_fill_nxt;
    assign o_full     = w_full;
    assign o_drop     = w_drop;

endmodule

// File: rtl/cam_frame_sched.sv
// Camera frame scheduler: sensor init with timeout/retry, then concurrent
// writer/reader over an NBUF-deep ring. All outputs are registered.
module cam_frame_sched
    import cam_pkg::*;
#(
    parameter int          NBUF      = 2,
    parameter int          BW        = 2,
    parameter logic [3:0]  SETTLE    = 4'd2,
    parameter logic [23:0] INIT_TMO  = 24'd5_000_000,
    parameter logic [15:0] RETRY_GAP = 16'd16
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_wr_frame,
    input  logic              i_rd_frame,
    input  logic              i_mode,
    output logic              o_init_en,
    output logic              o_run_en,
    output logic              o_read_en,
    output logic              o_r_idle,
    output logic [BW-1:0]     o_wr_buf,
    output logic [BW-1:0]     o_rd_buf,
    output logic [BW:0]       o_fill,
    output logic              o_init_err,
    output logic [DROP_W-1:0] o_drop_cnt
);

    state_t            r_state, w_nxt;
    logic [23:0]       r_tmo_cnt;
    logic [15:0]       r_gap_cnt;
    logic [3:0]        r_set_cnt;
    logic              r_init_en, r_run_en, r_read_en, r_r_idle, r_init_err;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              w_init_en_d, w_run_en_d, w_read_en_d, w_r_idle_d;
    logic              w_wr_acc, w_rd_acc, w_full, w_drop;
    logic [BW-1:0]     w_wr_buf, w_rd_buf;
    logic [BW:0]       w_fill, w_fill_nxt;

    // Pulses outside their enable window are ignored
    assign w_wr_acc = i_wr_frame & r_run_en;
    assign w_rd_acc = i_rd_frame & r_read_en;

    cam_ring_ptr #(.NBUF(NBUF), .BW(BW)) u_ring (
        .i_clk      (i_sys_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_acc   (w_wr_acc),
        .i_rd_acc   (w_rd_acc),
        .i_stalled  (r_state == ST_STALL),
        .i_mode     (i_mode),
        .o_wr_buf   (w_wr_buf),
        .o_rd_buf   (w_rd_buf),
        .o_fill     (w_fill),
        .o_fill_nxt (w_fill_nxt),
        .o_full     (w_full),
        .o_drop     (w_drop)
    );

    // State register
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) r_state <= ST_INIT;
        else          r_state <= w_nxt;
    end

    // Next-state logic; INIT_DONE wins over a timeout landing in the same cycle
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (i_init_done)
                    w_nxt = ST_SETTLE;
                else if ((INIT_TMO != 24'd0) && (r_tmo_cnt == INIT_TMO - 24'd1))
                    w_nxt = ST_RETRY;
            end
            ST_RETRY:  if (r_gap_cnt == RETRY_GAP - 16'd1) w_nxt = ST_INIT;
            ST_SETTLE: if (r_set_cnt == SETTLE - 4'd1)     w_nxt = ST_STREAM;
            ST_STREAM: if (w_full)                         w_nxt = ST_STALL;
            ST_STALL:  if (w_rd_acc)                       w_nxt = ST_SETTLE;
            default:                                       w_nxt = ST_INIT;
        endcase
    end

    // Output decode from the upcoming state; READ_EN lags a rising fill by one cycle but drops with it
    always_comb begin
        w_init_en_d = (w_nxt == ST_INIT);
        w_run_en_d  = (w_nxt == ST_STREAM);
        w_read_en_d = (|w_fill) && (|w_fill_nxt);
        w_r_idle_d  = (w_nxt == ST_STREAM) && !w_read_en_d;
    end

    // Registered outputs
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            r_init_en <= 1'b0;
            r_run_en  <= 1'b0;
            r_read_en <= 1'b0;
            r_r_idle  <= 1'b0;
        end else begin
            r_init_en <= w_init_en_d;
            r_run_en  <= w_run_en_d;
            r_read_en <= w_read_en_d;
            r_r_idle  <= w_r_idle_d;
        end
    end

    // Per-state counters (cleared whenever their state is left), sticky error, saturating drop count
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            r_tmo_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_set_cnt  <= '0;
            r_init_err <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_tmo_cnt <= (r_state == ST_INIT)   ? r_tmo_cnt + 24'd1 : 24'd0;
            r_gap_cnt <= (r_state == ST_RETRY)  ? r_gap_cnt + 16'd1 : 16'd0;
            r_set_cnt <= (r_state == ST_SETTLE) ? r_set_cnt + 4'd1  : 4'd0;
            if ((r_state == ST_INIT) && (w_nxt == ST_RETRY))
                r_init_err <= 1'b1;
            if (w_drop && (r_drop_cnt != {DROP_W{1'b1}}))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign o_init_en  = r_init_en;
    assign o_run_en   = r_run_en;
    assign o_read_en  = r_read_en;
    assign o_r_idle   = r_r_idle;
    assign o_wr_buf   = w_wr_buf;
    assign o_rd_buf   = w_rd_buf;
    assign o_fill     = w_fill;
    assign o_init_err = r_init_err;
    assign o_drop_cnt = r_drop_cnt;

endmodule
